// File: rtl/concat_write_ctrl.sv
// -----------------------------------------------------------------------------
// concat_write_ctrl
//
// Write sequencer in front of the concat FIFO. For every output pixel it drains
// ch_a_words words from source FIFO A, then ch_b_words words from source FIFO B.
// It writes them in that order into the concat FIFO, which builds a
// channel-concatenated feature map. A pixel burst starts only after the concat
// FIFO reports room for the whole burst (S_count / S_Ready handshake).
//
// Optional build macro: CONCAT_STALL_CNT_EN
//   When it is defined, the stall_cycles output counts cycles lost to concat FIFO
//   backpressure and to empty source FIFOs.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle pulse; latches configuration and starts a transfer
//   pix_num          number of pixels to transfer
//   ch_a_words       words per pixel taken from source A
//   ch_b_words       words per pixel taken from source B
//   a_dout, a_empty  source A read data (1-cycle latency) and empty flag
//   a_rd_en          source A read strobe
//   b_dout, b_empty  source B read data (1-cycle latency) and empty flag
//   b_rd_en          source B read strobe
//   S_count          burst size requested from the concat FIFO (latched)
//   S_Ready          concat FIFO has room for S_count words
//   wr_en, din       concat FIFO write strobe and data
//   busy             transfer in progress (includes the done cycle)
//   done             one-cycle pulse after the last word is written
//   stall_cycles     (CONCAT_STALL_CNT_EN only) saturating stall cycle count
// -----------------------------------------------------------------------------
module concat_write_ctrl #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 10,
  parameter int PIX_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PIX_BITS-1:0]  pix_num,
  input  logic [ADDR_BITS-1:0] ch_a_words,
  input  logic [ADDR_BITS-1:0] ch_b_words,
  input  logic [WIDTH-1:0]     a_dout,
  input  logic                 a_empty,
  output logic                 a_rd_en,
  input  logic [WIDTH-1:0]     b_dout,
  input  logic                 b_empty,
  output logic                 b_rd_en,
  output logic [ADDR_BITS:0]   S_count,
  input  logic                 S_Ready,
  output logic                 wr_en,
  output logic [WIDTH-1:0]     din,
  output logic                 busy,
`ifdef CONCAT_STALL_CNT_EN
  output logic [31:0]          stall_cycles,
`endif
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ_A,
    READ_B,
    NEXT,
    DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] CNT_ONE = ADDR_BITS'(1);
  localparam logic [PIX_BITS-1:0]  PIX_ONE = PIX_BITS'(1);

  state_t               state;
  state_t               state_n;
  logic [PIX_BITS-1:0]  pix_q;
  logic [ADDR_BITS-1:0] ch_a_q;
  logic [ADDR_BITS-1:0] ch_b_q;
  logic [ADDR_BITS-1:0] a_cnt;
  logic [ADDR_BITS-1:0] b_cnt;
  logic [PIX_BITS-1:0]  pix_cnt;
  logic                 next_wait;
  logic                 src_b_q;

  logic [ADDR_BITS:0]   start_sum;
  logic [ADDR_BITS-1:0] a_cnt_nxt;
  logic [ADDR_BITS-1:0] b_cnt_nxt;
  logic                 a_last;
  logic                 b_last;
  logic                 pix_inc;
  logic                 accept;

  // The sum is taken one bit wider than the channel counts, so it cannot wrap.
  assign start_sum = {1'b0, ch_a_words} + {1'b0, ch_b_words};
  assign accept    = (state == IDLE) && start;

  // Reads are combinational from state, so the first read goes out in the
  // cycle after CHECK sees S_Ready. Only one read state is live at a time, so
  // the two strobes are never high together.
  assign a_rd_en   = (state == READ_A) && !a_empty && (a_cnt < ch_a_q);
  assign b_rd_en   = (state == READ_B) && !b_empty && (b_cnt < ch_b_q);
  assign a_cnt_nxt = a_cnt + CNT_ONE;
  assign b_cnt_nxt = b_cnt + CNT_ONE;
  assign a_last    = a_rd_en && (a_cnt_nxt == ch_a_q);
  assign b_last    = b_rd_en && (b_cnt_nxt == ch_b_q);
  assign pix_inc   = b_last || (a_last && (ch_b_q == '0));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Source data arrives one cycle after the read strobe, in step with the
  // delayed wr_en. The data is gated, so din is zero whenever no write is made.
  assign din = wr_en ? (src_b_q ? b_dout : a_dout) : '0;

  // Next-state logic. NEXT holds for two cycles. This lets the last write land
  // and lets the registered S_Ready catch up before the next CHECK.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if ((pix_num == '0) || (start_sum == '0)) state_n = DONE;
          else                                      state_n = CHECK;
        end
      end
      CHECK: begin
        if (S_Ready) state_n = (ch_a_q == '0) ? READ_B : READ_A;
      end
      READ_A: begin
        if (a_last) state_n = (ch_b_q == '0) ? NEXT : READ_B;
      end
      READ_B: begin
        if (b_last) state_n = NEXT;
      end
      NEXT: begin
        if (next_wait) state_n = (pix_cnt == pix_q) ? DONE : CHECK;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, latched configuration, counters and the write pipeline.
  // The pixel counter advances on the final read of a pixel, so NEXT can
  // compare it against pix_q directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_q     <= '0;
      ch_a_q    <= '0;
      ch_b_q    <= '0;
      S_count   <= '0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      pix_cnt   <= '0;
      next_wait <= 1'b0;
      wr_en     <= 1'b0;
      src_b_q   <= 1'b0;
    end else begin
      state   <= state_n;
      wr_en   <= a_rd_en || b_rd_en;
      src_b_q <= b_rd_en;

      if (accept) begin
        pix_q   <= pix_num;
        ch_a_q  <= ch_a_words;
        ch_b_q  <= ch_b_words;
        S_count <= start_sum;
        a_cnt   <= '0;
        b_cnt   <= '0;
        pix_cnt <= '0;
      end else begin
        if (a_rd_en) a_cnt <= a_last ? '0 : a_cnt_nxt;
        if (b_rd_en) b_cnt <= b_last ? '0 : b_cnt_nxt;
        if (pix_inc) pix_cnt <= pix_cnt + PIX_ONE;
      end

      next_wait <= (state == NEXT) ? !next_wait : 1'b0;
    end
  end

`ifdef CONCAT_STALL_CNT_EN
  logic stall_hit;

  assign stall_hit = ((state == CHECK)  && !S_Ready) ||
                     ((state == READ_A) && a_empty)  ||
                     ((state == READ_B) && b_empty);

  // Saturating stall counter. It restarts on every accepted start, so each
  // transfer reports only its own stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (stall_hit && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_concat_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_concat_write_ctrl
//
// Directed self-checking bench for concat_write_ctrl. Two small source FIFO
// models return tagged words (0xAA.. for A, 0xBB.. for B) with one cycle of
// read latency. A negedge monitor logs every concat FIFO write. Inputs are
// driven 1 time unit after the rising edge. Optional macro:
// CONCAT_STALL_CNT_EN enables the stall counter checks.
// -----------------------------------------------------------------------------
module tb_concat_write_ctrl;

  localparam int W  = 128;
  localparam int AB = 10;
  localparam int PB = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PB-1:0] pix_num;
  logic [AB-1:0] ch_a_words;
  logic [AB-1:0] ch_b_words;
  logic [W-1:0]  a_dout = '0;
  logic          a_empty;
  logic          a_rd_en;
  logic [W-1:0]  b_dout = '0;
  logic          b_empty;
  logic          b_rd_en;
  logic [AB:0]   S_count;
  logic          S_Ready;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
`ifdef CONCAT_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  concat_write_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .PIX_BITS(PB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_num    (pix_num),
    .ch_a_words (ch_a_words),
    .ch_b_words (ch_b_words),
    .a_dout     (a_dout),
    .a_empty    (a_empty),
    .a_rd_en    (a_rd_en),
    .b_dout     (b_dout),
    .b_empty    (b_empty),
    .b_rd_en    (b_rd_en),
    .S_count    (S_count),
    .S_Ready    (S_Ready),
    .wr_en      (wr_en),
    .din        (din),
    .busy       (busy),
`ifdef CONCAT_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] make_word(input logic [7:0] tag, input int idx);
    return {tag, 88'd0, idx};
  endfunction

  // Source FIFO models: each read returns the next tagged word one cycle later.
  int a_idx = 0;
  int b_idx = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_en) begin
      a_dout <= make_word(8'hAA, a_idx);
      a_idx  <= a_idx + 1;
    end
    if (b_rd_en) begin
      b_dout <= make_word(8'hBB, b_idx);
      b_idx  <= b_idx + 1;
    end
  end

  // Write/event monitor, sampled mid-cycle.
  logic [W-1:0] wr_log [0:511];
  int           wr_cyc [0:511];
  int wr_cnt = 0;
  int a_rd_cnt = 0;
  int b_rd_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_log[wr_cnt % 512] <= din;
      wr_cyc[wr_cnt % 512] <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (a_rd_en) a_rd_cnt <= a_rd_cnt + 1;
    if (b_rd_en) b_rd_cnt <= b_rd_cnt + 1;
    if (a_rd_en && b_rd_en) overlap_cnt <= overlap_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called 1 unit after a rising edge; returns 1 unit after the edge that accepted start.
  task automatic pulse_start(input logic [PB-1:0] p, input logic [AB-1:0] ca,
                             input logic [AB-1:0] cb, output int sc);
    pix_num    = p;
    ch_a_words = ca;
    ch_b_words = cb;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sc    = cyc;
  endtask

  // Returns at the falling edge where done is seen, or when the limit expires.
  task automatic wait_for_done(input int limit, output bit seen, output int dcyc);
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; pix_num = '0; ch_a_words = '0; ch_b_words = '0;
    a_empty = 1'b0; b_empty = 1'b0; S_Ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({a_rd_en, b_rd_en, wr_en, busy, done} !== 5'b0)
      $display("[TB] FAIL reset_strobes: got %b required 00000", {a_rd_en, b_rd_en, wr_en, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (din !== '0) $display("[TB] FAIL reset_din: got %h required 0", din);
    else pass_cnt++;
    total_cnt++;
    if (S_count !== '0) $display("[TB] FAIL reset_S_count: got %0d required 0", S_count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single_pixel();
    int base, a0, b0, dbase, sc, dcyc, lag;
    bit seen;
    logic [W-1:0] exp;
    base = wr_cnt; a0 = a_idx; b0 = b_idx; dbase = done_cnt;
    S_Ready = 1'b1;
    pulse_start(20'd1, 10'd2, 10'd3, sc);
    total_cnt++;
    if (S_count !== 11'd5) $display("[TB] FAIL single_S_count: got %0d required 5", S_count);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b required 1", busy);
    else pass_cnt++;
    wait_for_done(40, seen, dcyc);
    @(posedge clk); #1;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL single_done_seen: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 5) $display("[TB] FAIL single_write_count: got %0d required 5", wr_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if (wr_cyc[base % 512] !== sc + 2)
      $display("[TB] FAIL single_first_write_cycle: got %0d required %0d", wr_cyc[base % 512], sc + 2);
    else pass_cnt++;
    total_cnt++;
    if (wr_cyc[(base + 4) % 512] !== sc + 6)
      $display("[TB] FAIL single_last_write_cycle: got %0d required %0d", wr_cyc[(base + 4) % 512], sc + 6);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      exp = (i < 2) ? make_word(8'hAA, a0 + i) : make_word(8'hBB, b0 + i - 2);
      total_cnt++;
      if (wr_log[(base + i) % 512] !== exp)
        $display("[TB] FAIL single_data[%0d]: got %h required %h", i, wr_log[(base + i) % 512], exp);
      else pass_cnt++;
    end
    lag = dcyc - (sc + 6);
    total_cnt++;
    if (lag < 1 || lag > 3) $display("[TB] FAIL single_done_lag: got %0d required 1..3", lag);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL single_after_done: got %b required 00", {busy, done});
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - dbase !== 1) $display("[TB] FAIL single_done_width: got %0d required 1", done_cnt - dbase);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int base, a0, b0, sc, dcyc, ra, rb, p, k;
    bit seen;
    logic [W-1:0] exp;
    base = wr_cnt; a0 = a_idx; b0 = b_idx;
    S_Ready = 1'b1;
    pulse_start(20'd4, 10'd4, 10'd4, sc);
    for (int i = 0; i < 40 && (wr_cnt - base) < 1; i++) begin
      @(posedge clk); #1;
    end
    S_Ready = 1'b0;
    for (int i = 0; i < 60 && (wr_cnt - base) < 8; i++) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (wr_cnt - base !== 8) $display("[TB] FAIL bp_pixel1_writes: got %0d required 8", wr_cnt - base);
    else pass_cnt++;
    // Pixel 1's last write was logged last cycle. The block is in NEXT now and in CHECK
    // for the following 20 cycles, with S_Ready held low.
    ra = a_rd_cnt; rb = b_rd_cnt;
    repeat (21) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if ((a_rd_cnt - ra) + (b_rd_cnt - rb) !== 0)
      $display("[TB] FAIL bp_reads_while_not_ready: got %0d required 0", (a_rd_cnt - ra) + (b_rd_cnt - rb));
    else pass_cnt++;
    S_Ready = 1'b1;
    wait_for_done(300, seen, dcyc);
    @(posedge clk); #1;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL bp_done_seen: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 32) $display("[TB] FAIL bp_write_count: got %0d required 32", wr_cnt - base);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      p = i / 8;
      k = i % 8;
      exp = (k < 4) ? make_word(8'hAA, a0 + 4 * p + k) : make_word(8'hBB, b0 + 4 * p + k - 4);
      total_cnt++;
      if (wr_log[(base + i) % 512] !== exp)
        $display("[TB] FAIL bp_data[%0d]: got %h required %h", i, wr_log[(base + i) % 512], exp);
      else pass_cnt++;
    end
`ifdef CONCAT_STALL_CNT_EN
    total_cnt++;
    if (stall_cycles !== 32'd20) $display("[TB] FAIL bp_stall_cycles: got %0d required 20", stall_cycles);
    else pass_cnt++;
    pulse_start(20'd0, 10'd4, 10'd4, sc);
    total_cnt++;
    if (stall_cycles !== 32'd0) $display("[TB] FAIL bp_stall_clear: got %0d required 0", stall_cycles);
    else pass_cnt++;
    wait_for_done(5, seen, dcyc);
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_starvation();
    int base, a0, b0, sc, dcyc, viol, ra;
    bit seen;
    logic [W-1:0] exp;
    base = wr_cnt; a0 = a_idx; b0 = b_idx; ra = a_rd_cnt;
    viol = 0; seen = 1'b0; dcyc = -1;
    S_Ready = 1'b1;
    pulse_start(20'd1, 10'd4, 10'd2, sc);
    for (int i = 0; i < 80; i++) begin
      a_empty = ~a_empty;
      @(negedge clk);
      if (a_rd_en && a_empty) viol++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    a_empty = 1'b0;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL starve_done_seen: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (viol !== 0) $display("[TB] FAIL starve_read_while_empty: got %0d required 0", viol);
    else pass_cnt++;
    total_cnt++;
    if (a_rd_cnt - ra !== 4) $display("[TB] FAIL starve_a_reads: got %0d required 4", a_rd_cnt - ra);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 6) $display("[TB] FAIL starve_write_count: got %0d required 6", wr_cnt - base);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      exp = (i < 4) ? make_word(8'hAA, a0 + i) : make_word(8'hBB, b0 + i - 4);
      total_cnt++;
      if (wr_log[(base + i) % 512] !== exp)
        $display("[TB] FAIL starve_data[%0d]: got %h required %h", i, wr_log[(base + i) % 512], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_channels();
    int base, b0, sc, dcyc, ra;
    bit seen;
    logic [W-1:0] exp;
    base = wr_cnt; b0 = b_idx; ra = a_rd_cnt;
    S_Ready = 1'b1;
    pulse_start(20'd3, 10'd0, 10'd2, sc);
    total_cnt++;
    if (S_count !== 11'd2) $display("[TB] FAIL zero_S_count: got %0d required 2", S_count);
    else pass_cnt++;
    wait_for_done(80, seen, dcyc);
    @(posedge clk); #1;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL zero_done_seen: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (a_rd_cnt - ra !== 0) $display("[TB] FAIL zero_a_reads: got %0d required 0", a_rd_cnt - ra);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 6) $display("[TB] FAIL zero_write_count: got %0d required 6", wr_cnt - base);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      exp = make_word(8'hBB, b0 + i);
      total_cnt++;
      if (wr_log[(base + i) % 512] !== exp)
        $display("[TB] FAIL zero_data[%0d]: got %h required %h", i, wr_log[(base + i) % 512], exp);
      else pass_cnt++;
    end
    // A transfer with no pixels finishes straight away.
    base = wr_cnt;
    pulse_start(20'd0, 10'd2, 10'd2, sc);
    wait_for_done(2, seen, dcyc);
    @(posedge clk); #1;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL zero_pix_done: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 0) $display("[TB] FAIL zero_pix_writes: got %0d required 0", wr_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_reset();
    int base, a0, b0, dbase, sc, dcyc;
    bit seen, found;
    base = wr_cnt;
    found = 1'b0;
    S_Ready = 1'b1;
    pulse_start(20'd4, 10'd4, 10'd4, sc);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (b_rd_en && (wr_cnt - base) >= 8) begin
        found = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (found !== 1'b1) $display("[TB] FAIL rst_reach_pixel2_b: got %b required 1", found);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if ({a_rd_en, b_rd_en, wr_en, busy, done} !== 5'b0)
      $display("[TB] FAIL rst_mid_strobes: got %b required 00000", {a_rd_en, b_rd_en, wr_en, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (din !== '0) $display("[TB] FAIL rst_mid_din: got %h required 0", din);
    else pass_cnt++;
    total_cnt++;
    if (S_count !== '0) $display("[TB] FAIL rst_mid_S_count: got %0d required 0", S_count);
    else pass_cnt++;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // A fresh transfer, with a second start while busy that must be ignored.
    base = wr_cnt; a0 = a_idx; b0 = b_idx; dbase = done_cnt;
    pulse_start(20'd1, 10'd1, 10'd1, sc);
    pix_num = 20'd5; ch_a_words = 10'd3; ch_b_words = 10'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (S_count !== 11'd2) $display("[TB] FAIL busy_start_S_count: got %0d required 2", S_count);
    else pass_cnt++;
    wait_for_done(40, seen, dcyc);
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL fresh_done_seen: got %b required 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - base !== 2) $display("[TB] FAIL fresh_write_count: got %0d required 2", wr_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if (wr_log[base % 512] !== make_word(8'hAA, a0))
      $display("[TB] FAIL fresh_data_a: got %h required %h", wr_log[base % 512], make_word(8'hAA, a0));
    else pass_cnt++;
    total_cnt++;
    if (wr_log[(base + 1) % 512] !== make_word(8'hBB, b0))
      $display("[TB] FAIL fresh_data_b: got %h required %h", wr_log[(base + 1) % 512], make_word(8'hBB, b0));
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - dbase !== 1) $display("[TB] FAIL fresh_done_count: got %0d required 1", done_cnt - dbase);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL fresh_busy_after: got %b required 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_starvation();
    test_zero_channels();
    test_back_to_back_reset();
    total_cnt++;
    if (overlap_cnt !== 0) $display("[TB] FAIL read_overlap: got %0d required 0", overlap_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
